reg_dump_uart: RTL and testbench

Serial register-file dumper placed downstream of the single-cycle CPU top. On a start pulse it steps the CPU's debug register-select port through x0..x31. It captures each 32-bit register value, formats it as 8 uppercase ASCII hex digits followed by CR LF, and transmits the result over an 8N1 UART TX line. This gives bench and board-level visibility of architectural state without a waveform viewer.

---
 rtl/reg_dump_uart.sv | 113 +++++++++++
 tb/tb_reg_dump_uart.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_uart.sv
// Register-file dumper: steps reg_sel through x0..x31 and sends each value as
// eight uppercase hex digits plus CR LF on an 8N1 UART line.
module reg_dump_uart #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   output logic [4:0]  reg_sel,
   input  logic [31:0] reg_data,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, SEL, LOAD, SEND} state_t;

   state_t        r_state;
   logic [TW-1:0] r_tmr;
   logic [3:0]    r_bit;    // frame position on the line: 0 start, 1..8 data, 9 stop
   logic [3:0]    r_byte;
   logic [4:0]    r_reg;
   logic [31:0]   r_snap;
   logic          r_tx;
   logic          r_busy;
   logic          r_done;

   logic [3:0]    w_nib;
   logic [7:0]    w_asc;
   logic [7:0]    w_byte;

   // Byte 0 carries the most significant nibble.
   always_comb begin
      w_nib  = r_snap[{~r_byte[2:0], 2'b00} +: 4];
      w_asc  = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
      w_byte = w_asc;
      if (r_byte == 4'd8) w_byte = 8'h0D;
      else if (r_byte == 4'd9) w_byte = 8'h0A;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_tmr   <= '0;
         r_bit   <= '0;
         r_byte  <= '0;
         r_reg   <= '0;
         r_snap  <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (start) begin
                  r_state <= SEL;
                  r_reg   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            SEL: r_state <= LOAD;
            LOAD: begin
               r_snap  <= reg_data;
               r_byte  <= '0;
               r_bit   <= '0;
               r_tmr   <= '0;
               r_tx    <= 1'b0;
               r_state <= SEND;
            end
            SEND: begin
               if (r_tmr != TMAX) begin
                  r_tmr <= r_tmr + 1'b1;
               end else begin
                  r_tmr <= '0;
                  if (r_bit != 4'd9) begin
                     r_bit <= r_bit + 1'b1;
                     r_tx  <= (r_bit < 4'd8) ? w_byte[r_bit[2:0]] : 1'b1;
                  end else if (r_byte != 4'd9) begin
                     // back-to-back bytes: next start bit follows the stop bit directly
                     r_byte <= r_byte + 1'b1;
                     r_bit  <= '0;
                     r_tx   <= 1'b0;
                  end else if (r_reg != 5'd31) begin
                     r_reg   <= r_reg + 1'b1;
                     r_state <= SEL;
                     r_tx    <= 1'b1;
                  end else begin
                     r_reg   <= '0;
                     r_byte  <= '0;
                     r_bit   <= '0;
                     r_state <= IDLE;
                     r_tx    <= 1'b1;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign reg_sel = r_reg;
   assign tx      = r_tx;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart: records tx per cycle and decodes frames against a
// text model of the expected dump.
module tb_reg_dump_uart;
   localparam int CPB  = 4;
   localparam int REGP = 2 + 100 * CPB;   // cycles per register
   localparam int DUMP = 32 * REGP;       // start-accept edge to done edge
   localparam int TLEN = 16000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  reg_sel;
   logic [31:0] reg_data;
   logic        tx, busy, done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int e0 = 0;
   bit rec_on = 1'b0;
   int mode = 0;
   bit corrupt = 1'b0;
   logic [31:0] junk = 32'h0;
   logic [31:0] rregs [32];

   bit       tr_tx   [TLEN];
   bit       tr_busy [TLEN];
   logic [4:0] tr_sel [TLEN];
   int       done_at [$];
   int       ovl = 0;

   reg_dump_uart #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rstn(rstn), .start(start), .reg_sel(reg_sel),
      .reg_data(reg_data), .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      reg_data = {4{3'b000, reg_sel}};
      if (mode == 1) reg_data = rregs[reg_sel] ^ (corrupt ? junk : 32'h0);
   end

   always @(negedge clk) begin
      if (rec_on && (cyc - e0) >= 0 && (cyc - e0) < TLEN) begin
         tr_tx[cyc - e0]   <= tx;
         tr_busy[cyc - e0] <= busy;
         tr_sel[cyc - e0]  <= reg_sel;
         if (done) done_at.push_back(cyc - e0);
         if (done && busy) ovl <= ovl + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
   endfunction

   function automatic logic [31:0] model_val(input int k);
      logic [7:0] b;
      b = 8'(k);
      return (mode == 1) ? rregs[k] : {4{b}};
   endfunction

   task automatic begin_dump(input bit hold);
      @(posedge clk); #1;
      e0 = cyc + 1;
      done_at.delete();
      ovl = 0;
      rec_on = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
   endtask

   // Decode every frame at the bit centres and compare with the expected text.
   task automatic check_stream(input string nm);
      logic [31:0] v;
      logic [7:0]  ch;
      logic [9:0]  obs;
      int p;
      for (int k = 0; k < 32; k++) begin
         v = model_val(k);
         chk($sformatf("%s sel r%0d", nm, k), 32'(tr_sel[2 + k * REGP + 50]), 32'(k));
         for (int j = 0; j < 10; j++) begin
            if (j < 8) ch = hexc(4'((v >> (28 - 4 * j)) & 32'hF));
            else ch = (j == 8) ? 8'h0D : 8'h0A;
            p = 2 + k * REGP + j * 10 * CPB;
            for (int b = 0; b < 10; b++) obs[b] = tr_tx[p + b * CPB + CPB / 2];
            chk($sformatf("%s frame r%0d b%0d", nm, k, j), 32'(obs), 32'({1'b1, ch, 1'b0}));
         end
      end
      chk({nm, " done count"}, 32'(done_at.size()), 32'd1);
      if (done_at.size() > 0) chk({nm, " done time"}, 32'(done_at[0]), 32'(DUMP));
      chk({nm, " done&busy"}, 32'(ovl), 32'd0);
      chk({nm, " busy early"}, 32'(tr_busy[1]), 32'd1);
      chk({nm, " busy last"}, 32'(tr_busy[DUMP - 1]), 32'd1);
      chk({nm, " busy end"}, 32'(tr_busy[DUMP]), 32'd0);
      chk({nm, " tx pre"}, 32'({tr_tx[0], tr_tx[1]}), 32'b11);
   endtask

   initial begin
      logic [9:0] fr;
      int p;
      int k;

      // reset held with random start
      for (int i = 0; i < 20; i++) begin
         start = 1'($urandom);
         @(negedge clk);
         chk("rst outs", {25'b0, tx, busy, done, reg_sel}, {25'b0, 1'b1, 1'b0, 1'b0, 5'd0});
      end
      start = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle outs", {25'b0, tx, busy, done, reg_sel}, {25'b0, 1'b1, 1'b0, 1'b0, 5'd0});
      end

      // dump 1: stub pattern, plus exact bit timing on register 10
      mode = 0;
      begin_dump(1'b0);
      repeat (DUMP + 40) @(posedge clk);
      check_stream("stub");
      p = 2 + 10 * REGP + 10 * CPB;
      fr = {1'b1, 8'h41, 1'b0};
      for (int c = 0; c < 10 * CPB; c++)
         chk($sformatf("A bit c%0d", c), 32'(tr_tx[p + c]), 32'(fr[c / CPB]));
      p = 11 * REGP;
      chk("gap hi0", 32'(tr_tx[p]), 32'd1);
      chk("gap hi1", 32'(tr_tx[p + 1]), 32'd1);
      chk("gap start", 32'(tr_tx[p + 2]), 32'd0);
      chk("gap stop", 32'(tr_tx[p - 1]), 32'd1);

      // dump 2: random register values, spurious starts, mid-line corruption
      mode = 1;
      for (int i = 0; i < 32; i++) rregs[i] = $urandom;
      k = $urandom_range(1, 30);
      junk = $urandom | 32'h1;
      begin_dump(1'b0);
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               repeat ($urandom_range(50, 580)) @(posedge clk);
               #1 start = 1'b1;
               @(posedge clk); #1 start = 1'b0;
            end
         end
         begin
            while (cyc < e0 + 2 + k * REGP + 100) @(posedge clk);
            #1 corrupt = 1'b1;
            while (cyc < e0 + (k + 1) * REGP - 5) @(posedge clk);
            #1 corrupt = 1'b0;
         end
      join
      while (cyc < e0 + DUMP + 40) @(posedge clk);
      check_stream("rand");

      // dump 3: start held high, re-accepted right after done
      mode = 0;
      begin_dump(1'b1);
      while (cyc < e0 + DUMP + 3) @(negedge clk);
      chk("hold done time", (done_at.size() > 0) ? 32'(done_at[0]) : 32'hFFFF_FFFF, 32'(DUMP));
      chk("hold busy re", 32'(tr_busy[DUMP + 1]), 32'd1);
      chk("hold sel re", 32'(tr_sel[DUMP + 1]), 32'd0);
      #1 start = 1'b0;
      // reset inside register 5, byte 3, frame bit 4 of the second dump
      while (cyc < e0 + DUMP + 1 + 2 + 5 * REGP + 3 * 10 * CPB + 4 * CPB) @(negedge clk);
      chk("pre-rst tx", 32'(tx), 32'd0);
      chk("pre-rst busy", 32'(busy), 32'd1);
      #1 rstn = 1'b0;
      #1;
      chk("rst tx", 32'(tx), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst sel", 32'(reg_sel), 32'd0);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (20) @(negedge clk);
      chk("post-rst tx", 32'(tx), 32'd1);
      chk("post-rst busy", 32'(busy), 32'd0);

      // dump 4: clean dump after reset
      begin_dump(1'b0);
      repeat (DUMP + 40) @(posedge clk);
      check_stream("after rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
